run_sorter: RTL and testbench



---
 rtl/bwt_pkg.sv | 33 +++
 rtl/run_insert_array.sv | 69 ++++++
 rtl/run_sorter.sv | 192 +++++++++++++++++++
 tb/tb_run_sorter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bwt_pkg.sv
// Shared types and constants for the BWT sort pipeline.
// Holds the run_sorter state encoding and the FIFO write-beat payload.
package bwt_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

  localparam byte_t PAD_VAL_DEF = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    FILL_L,
    DRAIN_L,
    FILL_R,
    DRAIN_R,
    PAD_R,
    START,
    WAIT_MERGE
  } rs_state_e;

  // One registered beat towards the two merge FIFOs.
  typedef struct packed {
    logic  wr_l;
    logic  wr_r;
    byte_t data;
  } fifo_wr_t;

  function automatic logic is_fill(input rs_state_e s);
    return (s == FILL_L) || (s == FILL_R);
  endfunction

endpackage

// File: rtl/run_insert_array.sv
// RUN_LEN-entry register array kept in ascending order by a parallel
// compare/shift insert, with tail padding and an indexed read port.
module run_insert_array
  import bwt_pkg::*;
#(
  parameter int unsigned RUN_LEN = 2,
  parameter int unsigned CNT_W   = 2,
  parameter byte_t       PAD_VAL = PAD_VAL_DEF
) (
  input  logic             clk,
  input  logic             ins_en,
  input  byte_t            ins_data,
  input  logic [CNT_W-1:0] cnt,
  input  logic             pad_en,
  input  logic [CNT_W-1:0] rd_idx,
  output byte_t            rd_data_c
);

  byte_t               arr_q [RUN_LEN];
  byte_t               arr_d [RUN_LEN];
  logic  [RUN_LEN-1:0] gt_c;

  // Valid entries strictly greater than the new byte; ties stay below it.
  always_comb begin
    gt_c = '0;
    for (int unsigned i = 0; i < RUN_LEN; i++) begin
      gt_c[i] = (CNT_W'(i) < cnt) && (arr_q[i] > ins_data);
    end
  end

  always_comb begin
    arr_d = arr_q;
    if (ins_en) begin
      for (int unsigned i = 0; i < RUN_LEN; i++) begin
        if (gt_c[i] || (CNT_W'(i) == cnt)) begin
          arr_d[i] = ins_data;
        end
      end
      // Shift wins over the insert slot so greater entries move up intact.
      for (int unsigned i = 1; i < RUN_LEN; i++) begin
        if (gt_c[i-1]) begin
          arr_d[i] = arr_q[i-1];
        end
      end
    end else if (pad_en) begin
      for (int unsigned i = 0; i < RUN_LEN; i++) begin
        if (CNT_W'(i) >= cnt) begin
          arr_d[i] = PAD_VAL;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < RUN_LEN; i++) begin
      arr_q[i] <= arr_d[i];
    end
  end

  always_comb begin
    rd_data_c = arr_q[0];
    for (int unsigned i = 0; i < RUN_LEN; i++) begin
      if (rd_idx == CNT_W'(i)) begin
        rd_data_c = arr_q[i];
      end
    end
  end

endmodule

// File: rtl/run_sorter.sv
// Sorts input bytes into two runs and feeds them to the merge FIFOs L and R.
// Optional output-order checker: define RUN_SORTER_ORDER_CHECK_EN.
module run_sorter
  import bwt_pkg::*;
#(
  parameter int unsigned RUN_LEN = 2,
  parameter int unsigned CNT_W   = 2,
  parameter byte_t       PAD_VAL = PAD_VAL_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [BYTE_W-1:0] wr_data,
  output logic              wr_l,
  output logic              wr_r,
  input  logic              full_l,
  input  logic              full_r,
  output logic              merge_start,
  input  logic              merge_done,
  output logic              err
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RUN_LEN - 1);
  localparam logic [CNT_W-1:0] RUN_CNT  = CNT_W'(RUN_LEN);

  rs_state_e        state_q, state_d;
  logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [CNT_W-1:0] rd_idx_q, rd_idx_d;
  logic             last_seen_q, last_seen_d;
  fifo_wr_t         wr_q, wr_d;
  logic             merge_start_q, merge_start_d;

  logic             ins_en_c;
  logic             pad_en_c;
  byte_t            rd_data_c;
  logic             side_full_c;

  run_insert_array #(
    .RUN_LEN (RUN_LEN),
    .CNT_W   (CNT_W),
    .PAD_VAL (PAD_VAL)
  ) u_arr (
    .clk       (clk),
    .ins_en    (ins_en_c),
    .ins_data  (in_data),
    .cnt       (fill_cnt_q),
    .pad_en    (pad_en_c),
    .rd_idx    (rd_idx_q),
    .rd_data_c (rd_data_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      fill_cnt_q    <= '0;
      rd_idx_q      <= '0;
      last_seen_q   <= 1'b0;
      wr_q          <= '0;
      merge_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fill_cnt_q    <= fill_cnt_d;
      rd_idx_q      <= rd_idx_d;
      last_seen_q   <= last_seen_d;
      wr_q          <= wr_d;
      merge_start_q <= merge_start_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    fill_cnt_d    = fill_cnt_q;
    rd_idx_d      = rd_idx_q;
    last_seen_d   = last_seen_q;
    wr_d          = '0;
    wr_d.data     = wr_q.data;
    merge_start_d = 1'b0;
    ins_en_c      = 1'b0;
    pad_en_c      = 1'b0;
    in_ready      = 1'b0;
    side_full_c   = (state_q == DRAIN_L) ? full_l : full_r;

    unique case (state_q)
      IDLE: begin
        state_d    = FILL_L;
        fill_cnt_d = '0;
      end

      FILL_L, FILL_R: begin
        in_ready = is_fill(state_q) && (fill_cnt_q < RUN_CNT);
        if (in_valid && in_ready) begin
          ins_en_c   = 1'b1;
          fill_cnt_d = fill_cnt_q + CNT_W'(1);
          if (in_last) begin
            last_seen_d = 1'b1;
          end
          if (in_last || (fill_cnt_q == LAST_IDX)) begin
            state_d  = (state_q == FILL_L) ? DRAIN_L : DRAIN_R;
            rd_idx_d = '0;
          end
        end
      end

      DRAIN_L, DRAIN_R: begin
        // Slot 0 always holds real data, so padding the tail here is safe.
        pad_en_c = (rd_idx_q == '0);
        if (!side_full_c) begin
          wr_d.data = rd_data_c;
          wr_d.wr_l = (state_q == DRAIN_L);
          wr_d.wr_r = (state_q == DRAIN_R);
          rd_idx_d  = rd_idx_q + CNT_W'(1);
          if (rd_idx_q == LAST_IDX) begin
            rd_idx_d   = '0;
            fill_cnt_d = '0;
            if (state_q == DRAIN_R) begin
              state_d = START;
            end else begin
              state_d = last_seen_q ? PAD_R : FILL_R;
            end
          end
        end
      end

      PAD_R: begin
        if (!full_r) begin
          wr_d.data = PAD_VAL;
          wr_d.wr_r = 1'b1;
          rd_idx_d  = rd_idx_q + CNT_W'(1);
          if (rd_idx_q == LAST_IDX) begin
            rd_idx_d = '0;
            state_d  = START;
          end
        end
      end

      START: begin
        merge_start_d = 1'b1;
        state_d       = WAIT_MERGE;
      end

      WAIT_MERGE: begin
        if (merge_done) begin
          state_d     = FILL_L;
          fill_cnt_d  = '0;
          last_seen_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign wr_data     = wr_q.data;
  assign wr_l        = wr_q.wr_l;
  assign wr_r        = wr_q.wr_r;
  assign merge_start = merge_start_q;

`ifdef RUN_SORTER_ORDER_CHECK_EN
  byte_t prev_q, prev_d;
  logic  err_q, err_d;

  // Each run must leave in non-decreasing order; its first write restarts the check.
  always_comb begin
    prev_d = prev_q;
    err_d  = err_q;
    if (wr_d.wr_l || wr_d.wr_r) begin
      if ((rd_idx_q != '0) && (wr_d.data < prev_q)) begin
        err_d = 1'b1;
      end
      prev_d = wr_d.data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q <= '0;
      err_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_run_sorter.sv
// Randomized self-checking bench for run_sorter against a block-level sort model.
module tb_run_sorter;

  localparam int RL = 2;
  localparam logic [7:0] PAD = 8'hFF;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic [7:0] wr_data;
  logic       wr_l, wr_r;
  logic       full_l = 1'b0;
  logic       full_r = 1'b0;
  logic       merge_start;
  logic       merge_done = 1'b0;
  logic       err;

  bit         rand_full = 1'b0;
  logic       hold_l = 1'b0;
  logic       hold_r = 1'b0;

  int checks = 0;
  int failures = 0;

  bq_t got_l, got_r;
  int  cyc = 0, ms_total = 0, ms_cyc = 0, last_wr_r_cyc = 0, both_cnt = 0;
  int  base_l = 0, base_r = 0, base_ms = 0;

  always #5 clk = ~clk;

  run_sorter #(
    .RUN_LEN (RL),
    .CNT_W   (2),
    .PAD_VAL (PAD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .wr_data     (wr_data),
    .wr_l        (wr_l),
    .wr_r        (wr_r),
    .full_l      (full_l),
    .full_r      (full_r),
    .merge_start (merge_start),
    .merge_done  (merge_done),
    .err         (err)
  );

  // FIFO-side observer: records every write and merge_start cycle.
  always @(negedge clk) begin
    cyc++;
    if (wr_l) got_l.push_back(wr_data);
    if (wr_r) begin
      got_r.push_back(wr_data);
      last_wr_r_cyc = cyc;
    end
    if (wr_l && wr_r) both_cnt++;
    if (merge_start) begin
      ms_total++;
      ms_cyc = cyc;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      full_l = rand_full ? ($urandom_range(0, 3) == 0) : hold_l;
      full_r = rand_full ? ($urandom_range(0, 3) == 0) : hold_r;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected FIFO side: real bytes padded to RL, in ascending value order.
  function automatic bq_t sorted_side(input bq_t in);
    bq_t s, res;
    s = in;
    while (s.size() < RL) s.push_back(PAD);
    for (int v = 0; v < 256; v++) begin
      foreach (s[i]) if (s[i] == 8'(v)) res.push_back(s[i]);
    end
    return res;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic last);
    bit done;
    done = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    for (int t = 0; t < 400 && !done; t++) begin
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!done) chk("send_timeout", 32'(done), 32'd1);
  endtask

  task automatic check_round(input bq_t el, input bq_t er);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 400 && !seen; t++) begin
      @(negedge clk);
      if (ms_total > base_ms) seen = 1'b1;
    end
    chk("merge_start_seen", 32'(seen), 32'd1);
    if (seen) begin
      chk("l_count", 32'(got_l.size() - base_l), 32'(RL));
      chk("r_count", 32'(got_r.size() - base_r), 32'(RL));
      for (int i = 0; i < RL; i++) begin
        if (base_l + i < got_l.size()) chk($sformatf("l_data[%0d]", i), 32'(got_l[base_l+i]), 32'(el[i]));
        if (base_r + i < got_r.size()) chk($sformatf("r_data[%0d]", i), 32'(got_r[base_r+i]), 32'(er[i]));
      end
      chk("ms_after_last_wr_r", 32'(ms_cyc - last_wr_r_cyc), 32'd1);
    end
    chk("strobe_overlap", 32'(both_cnt), 32'd0);
    repeat (2) @(negedge clk);
    chk("wait_in_ready", 32'(in_ready), 32'd0);
    chk("ms_pulse_width", 32'(ms_total - base_ms), 32'd1);
    chk("err_clean", 32'(err), 32'd0);
    merge_done = 1'b1;
    @(negedge clk);
    merge_done = 1'b0;
    base_l  = got_l.size();
    base_r  = got_r.size();
    base_ms = ms_total;
  endtask

  task automatic run_block(input bq_t blk);
    bq_t lq, rq;
    int  pos, chunk;
    pos = 0;
    while (pos < blk.size()) begin
      chunk = blk.size() - pos;
      if (chunk > 2 * RL) chunk = 2 * RL;
      lq.delete();
      rq.delete();
      for (int i = 0; i < chunk; i++) begin
        send_byte(blk[pos+i], (pos + i) == (blk.size() - 1));
        if (i < RL) lq.push_back(blk[pos+i]);
        else        rq.push_back(blk[pos+i]);
      end
      check_round(sorted_side(lq), sorted_side(rq));
      pos += chunk;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_wr_l", 32'(wr_l), 32'd0);
    chk("rst_wr_r", 32'(wr_r), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_merge_start", 32'(merge_start), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(in_ready), 32'd1);
    base_l  = got_l.size();
    base_r  = got_r.size();
    base_ms = ms_total;
  endtask

  initial begin
    bq_t blk;
    int  n;

    #2;
    do_reset();

    blk = {8'd5, 8'd3, 8'd9, 8'd1};
    run_block(blk);

    blk = {8'd7, 8'd7};
    run_block(blk);

    blk = {8'd4};
    run_block(blk);

    // FIFO L backpressure for three cycles in the middle of a drain.
    hold_l = 1'b1;
    send_byte(8'd5, 1'b0);
    send_byte(8'd3, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("stall_wr_l", 32'(wr_l), 32'd0);
    end
    hold_l = 1'b0;
    send_byte(8'd9, 1'b0);
    send_byte(8'd1, 1'b1);
    blk = {8'd5, 8'd3};
    begin
      bq_t r2;
      r2 = {8'd9, 8'd1};
      check_round(sorted_side(blk), sorted_side(r2));
    end

    // merge_done while filling must be ignored.
    @(negedge clk);
    merge_done = 1'b1;
    @(negedge clk);
    merge_done = 1'b0;
    blk = {8'd40, 8'd20, 8'd30};
    run_block(blk);

    rand_full = 1'b1;
    for (int b = 0; b < 25; b++) begin
      blk.delete();
      n = $urandom_range(1, 9);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 1) == 0) blk.push_back(8'($urandom_range(0, 7)));
        else                           blk.push_back(8'($urandom_range(0, 255)));
      end
      run_block(blk);
    end
    rand_full = 1'b0;

    // Reset in the middle of DRAIN_R, then a fresh block.
    send_byte(8'd200, 1'b0);
    send_byte(8'd100, 1'b0);
    send_byte(8'd60, 1'b0);
    send_byte(8'd30, 1'b1);
    @(negedge clk);
    chk("wr_r_lat_cycle1", 32'(wr_r), 32'd0);
    @(negedge clk);
    chk("wr_r_lat_cycle2", 32'(wr_r), 32'd1);
    chk("wr_r_first_data", 32'(wr_data), 32'd30);
    #2;
    do_reset();
    blk = {8'd8, 8'd2, 8'd6};
    run_block(blk);

`ifdef RUN_SORTER_ORDER_CHECK_EN
    send_byte(8'd5, 1'b0);
    send_byte(8'd9, 1'b0);
    @(negedge clk);
    @(negedge clk);
    force dut.u_arr.rd_data_c = 8'h00;
    @(negedge clk);
    release dut.u_arr.rd_data_c;
    chk("order_err_set", 32'(err), 32'd1);
    repeat (6) @(negedge clk);
    chk("order_err_sticky", 32'(err), 32'd1);
    do_reset();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
